// File: rtl/xor_arbiter_if.sv
// xor_arbiter_if: request/response bundle between two requesters, a consumer and xor_arbiter.
//   master: drives req_valid, req_a0/1, req_b0/1, rsp_ready; observes req_ready, rsp_*, done_count
//   slave : the arbiter side, directions reversed
interface xor_arbiter_if #(parameter int WIDTH = 32);
    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       req_ready;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_ready;
    logic [15:0]      done_count;
    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, done_count
    );
    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, done_count
    );
endinterface

// File: rtl/xor_arbiter.sv
// xor_arbiter: two requesters share one registered XOR datapath under round-robin arbitration.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : xor_arbiter_if.slave (requests in, req_ready/response/done_count out)
module xor_arbiter #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    xor_arbiter_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             id_q, id_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             eligible, gnt_idx, acc, consume;
    always_comb begin
        // a slot frees up when nothing is held or the held result leaves this cycle
        eligible      = !reset && (state_q == IDLE || bus.rsp_ready);
        // ptr_q names the last winner, so under contention the other side goes next
        gnt_idx       = &bus.req_valid ? ~ptr_q : bus.req_valid[1];
        bus.req_ready = (eligible && |bus.req_valid) ? {gnt_idx, ~gnt_idx} : 2'b00;
        acc           = |(bus.req_valid & bus.req_ready);
        consume       = state_q == HOLD && bus.rsp_ready;
        state_d       = (acc || (state_q == HOLD && !bus.rsp_ready)) ? HOLD : IDLE;
        ptr_d         = acc ? gnt_idx : ptr_q;
        a_d           = acc ? (gnt_idx ? bus.req_a1 : bus.req_a0) : a_q;
        b_d           = acc ? (gnt_idx ? bus.req_b1 : bus.req_b0) : b_q;
        id_d          = acc ? gnt_idx : id_q;
        cnt_d         = cnt_q + {15'd0, consume};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.rsp_valid  = state_q == HOLD;
    assign bus.rsp_data   = a_q ^ b_q;
    assign bus.rsp_id     = id_q;
    assign bus.done_count = cnt_q;
endmodule

// File: doc/xor_arbiter.md
XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
- REQ-001: Parameter WIDTH, default 32, data width of operands and result.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: reset  input  1  asynchronous, active-high reset.
- REQ-004: req_valid  input  2  per-requester request valid; bit i = requester i.
- REQ-005: req_a0, req_a1  input  WIDTH each  operand A of requester 0 / 1.
- REQ-006: req_b0, req_b1  input  WIDTH each  operand B (mask) of requester 0 / 1.
- REQ-007: req_ready  output  2  per-requester accept; bit i high = requester i transfers this cycle if req_valid[i].
- REQ-008: rsp_valid  output  1  result valid.
- REQ-009: rsp_data  output  WIDTH  result = A ^ B of the accepted request.
- REQ-010: rsp_id  output  1  index of the requester that owns rsp_data.
- REQ-011: rsp_ready  input  1  consumer accepts the result when high with rsp_valid.
- REQ-012: done_count  output  16  number of results consumed since reset.

Function
- REQ-013: The block shall share one registered XOR datapath between two requesters.
  - Accepted A and B are captured into operand registers.
  - rsp_data is the XOR of the two registers.
- REQ-014: Request transfer: a request from requester i is accepted when req_valid[i] && req_ready[i] at a rising edge.
- REQ-015: At most one bit of req_ready shall be high in any cycle.
- REQ-016: Latency: a request accepted at edge t shall present rsp_valid=1 with its result from edge t until the edge at which rsp_ready=1.
- REQ-017: The FSM has exactly two states:
  - IDLE: no result held.
  - HOLD: result held, rsp_valid=1.
- REQ-018: IDLE transitions:
  - IDLE -> HOLD on any accepted request.
  - Otherwise stay in IDLE.
- REQ-019: HOLD transitions:
  - With rsp_ready=1 and a new request accepted in the same cycle: stay in HOLD and load the new operands (back-to-back, no bubble).
  - With rsp_ready=1 and no request accepted: go to IDLE.
  - With rsp_ready=0: stay in HOLD with rsp_data and rsp_id frozen.
- REQ-020: Grant is eligible only when state=IDLE or (state=HOLD and rsp_ready=1).
  - req_ready shall be combinational from req_valid, state, rsp_ready and the priority pointer.
  - req_ready is 2'b00 when not eligible.
- REQ-021: Arbitration is round-robin using a 1-bit pointer naming the last granted requester.
  - With both requesting, the other requester is granted.
  - With one requesting, that one is granted.
- REQ-022: The pointer shall update only on an accepted transfer, to the accepted index.
  - An offered but unaccepted grant does not move the pointer.
- REQ-023: With both requesters continuously valid and rsp_ready=1, grants shall strictly alternate 0,1,0,1,...
- REQ-024: req_ready shall not depend on req_a*/req_b*.
- REQ-025: rsp_id shall equal the index accepted with the held operands.
- REQ-026: done_count shall increment by 1 on each edge with rsp_valid && rsp_ready.
  - It wraps from 16'hFFFF to 16'h0000.
- REQ-027: Operand registers and rsp_id shall not change while in HOLD with rsp_ready=0.

Reset
- REQ-028: While reset=1, asynchronously and independent of clk:
  - State=IDLE, rsp_valid=0, rsp_data=0 (operand registers 0), rsp_id=0, done_count=0.
  - Pointer=1, so requester 0 wins the first contention.
- REQ-029: While reset=1, req_ready shall be 2'b00.
- REQ-030: Reset asserted while in HOLD shall discard the held result.
  - No done_count increment occurs for the discarded result.
- REQ-031: After reset deassertion, the first accept may occur at the first rising edge with reset=0.

Verification
- REQ-032: Single request: req_valid=01, req_a0=32'hFFFF0000, req_b0=32'h0F0F0F0F, rsp_ready=1.
  - Expect rsp_valid=1 the next cycle, rsp_data=32'hF0F00F0F, rsp_id=0, then done_count=1.
- REQ-033: Contention after reset: req_valid=11, rsp_ready=1 for 4 cycles.
  - Expect rsp_id sequence 0,1,0,1 with no idle cycles, and done_count=4.
- REQ-034: Backpressure: hold rsp_ready=0 for 3 cycles with req_valid=11.
  - Expect req_ready=00 and rsp_data/rsp_id stable.
  - On rsp_ready=1, expect the old result consumed and the next requester granted in the same cycle.
- REQ-035: Reset mid-HOLD: assert reset while rsp_valid=1 and rsp_ready=0.
  - Expect rsp_valid=0, rsp_data=0 and done_count=0 immediately (asynchronously).
- REQ-036: Wrap: force 65537 consumed results.
  - Expect done_count=1 after 16'hFFFF -> 16'h0000 -> 16'h0001.
- REQ-037: Pointer hold: requester 1 valid alone with rsp_ready=0 in HOLD, then requester 0 raises valid.
  - Expect the grant to go to the requester not last accepted.
  - Expect the pointer unchanged by the unaccepted cycles.
